// File: rtl/prog_clk_divider_pkg.sv
// -----------------------------------------------------------------------------
// prog_clk_divider_pkg
//
// Purpose : Shared constants for the programmable clock divider. Holds the
//           default counter width, the default divisor loaded at reset and the
//           smallest divisor the block will accept.
//
// Contents: CNT_W_DEF       - default counter/divisor width in bits
//           DEFAULT_DIV_DEF - default divisor N loaded at reset
//           MIN_DIV         - minimum legal divisor (a divide-by-1 is legal)
// -----------------------------------------------------------------------------
package prog_clk_divider_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 2;
  localparam int MIN_DIV         = 1;

endpackage : prog_clk_divider_pkg

// File: rtl/prog_clk_divider_if.sv
// -----------------------------------------------------------------------------
// prog_clk_divider_if
//
// Purpose : Bundles the control and status signals of the programmable clock
//           divider. Clock and reset stay outside as plain ports.
//
// Signals : en       - count enable (1 = run, 0 = hold idle)
//           div_val  - requested divisor, sampled when div_load = 1
//           div_load - one-cycle request to change the divisor
//           div_clk  - divided clock, period N clk cycles
//           tick     - one-cycle pulse once per N enabled cycles
//           div_pend - an accepted divisor is waiting to be applied
//           div_ack  - one-cycle pulse when a pending divisor takes effect
//           div_err  - one-cycle pulse when a load with div_val = 0 is rejected
//
// Modports: master - the controller (drives en/div_val/div_load)
//           slave  - the divider itself
// -----------------------------------------------------------------------------
interface prog_clk_divider_if
  import prog_clk_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_clk;
  logic             tick;
  logic             div_pend;
  logic             div_ack;
  logic             div_err;

  modport master (
    output en,
    output div_val,
    output div_load,
    input  div_clk,
    input  tick,
    input  div_pend,
    input  div_ack,
    input  div_err
  );

  modport slave (
    input  en,
    input  div_val,
    input  div_load,
    output div_clk,
    output tick,
    output div_pend,
    output div_ack,
    output div_err
  );

endinterface : prog_clk_divider_if

// File: rtl/prog_clk_divider.sv
// -----------------------------------------------------------------------------
// prog_clk_divider
//
// Purpose : Programmable integer clock divider. A free-running counter wraps
//           every N enabled cycles, producing a registered divided clock
//           (high ceil(N/2), low floor(N/2) cycles) and a one-cycle tick at
//           each wrap. New divisors go into a shadow register and are applied
//           only at a period boundary (or while idle), so div_clk never
//           shows a truncated period or a glitch.
//
// Ports   : clk   - single clock, all state updates on its rising edge
//           reset - asynchronous active-low reset
//           bus   - prog_clk_divider_if.slave (en, div_val, div_load in;
//                   div_clk, tick, div_pend, div_ack, div_err out)
//
// Params  : CNT_W       - counter/divisor width, 2..32
//           DEFAULT_DIV - divisor loaded at reset, 1..2^CNT_W-1
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module prog_clk_divider
  import prog_clk_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  prog_clk_divider_if.slave        bus
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(MIN_DIV);

  // State: counter, active divisor N, shadow divisor S, pending flag P.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q,   n_d;
  logic [CNT_W-1:0] s_q,   s_d;
  logic             p_q,   p_d;

  // Registered outputs.
  logic             div_clk_q, div_clk_d;
  logic             tick_q,    tick_d;
  logic             ack_q,     ack_d;
  logic             err_q,     err_d;

  logic             wrap;
  logic             apply;
  logic             load_ok;
  logic             load_bad;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Last count of the current period under the active divisor.
    wrap     = (cnt_q == (n_q - ONE));
    // A pending divisor is applied at a period boundary, or immediately while
    // idle since there is no period in progress to protect.
    apply    = p_q && (!bus.en || wrap);
    load_ok  = bus.div_load && (bus.div_val != '0);
    load_bad = bus.div_load && (bus.div_val == '0);

    cnt_d     = '0;
    n_d       = n_q;
    s_d       = s_q;
    p_d       = p_q;
    tick_d    = 1'b0;
    div_clk_d = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    // Counter: restart on apply, wrap or idle; otherwise advance.
    if (!apply && bus.en && !wrap) begin
      cnt_d = cnt_q + ONE;
    end

    // Apply uses the shadow value present before this edge; a load arriving
    // on the same edge is captured below and stays pending for the next
    // boundary.
    if (apply) begin
      n_d   = s_q;
      p_d   = 1'b0;
      ack_d = 1'b1;
    end

    if (load_ok) begin
      s_d = bus.div_val;
      p_d = 1'b1;
    end

    err_d  = load_bad;

    // Tick marks the end of a period measured with the divisor that was
    // active during it.
    tick_d = bus.en && wrap;

    // Divided clock is derived from the count it will hold after this edge
    // and the divisor that will govern it, so a freshly applied divisor
    // starts its first period with the correct phase.
    if (bus.en) begin
      div_clk_d = (cnt_d >= (n_d >> 1));
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      n_q       <= RST_DIV;
      s_q       <= RST_DIV;
      p_q       <= 1'b0;
      div_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      s_q       <= s_d;
      p_q       <= p_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.div_clk  = div_clk_q;
  assign bus.tick     = tick_q;
  assign bus.div_pend = p_q;
  assign bus.div_ack  = ack_q;
  assign bus.div_err  = err_q;

endmodule : prog_clk_divider

// File: tb/tb_prog_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_divider
//
// Directed bench for prog_clk_divider with CNT_W=8, DEFAULT_DIV=4. Expected
// output words are {div_clk, tick, div_pend, div_ack, div_err}, sampled 1 time
// unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_prog_clk_divider;

  localparam int W = 8;

  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] val;
    logic [4:0]   exp;
  } vec_t;

  logic clk;
  logic reset;

  int n_pass;
  int n_total;

  vec_t tbl[$];

  prog_clk_divider_if #(.CNT_W(W)) bus ();

  prog_clk_divider #(
    .CNT_W       (W),
    .DEFAULT_DIV (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {bus.div_clk, bus.tick, bus.div_pend, bus.div_ack, bus.div_err};
  endfunction

  task automatic check(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = outs();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got clk/tick/pend/ack/err=%b, expected %b", nm, act, exp);
  endtask

  task automatic step(input logic e, input logic ld, input logic [W-1:0] v,
                      input logic [4:0] exp, input string nm);
    bus.en       = e;
    bus.div_load = ld;
    bus.div_val  = v;
    @(posedge clk);
    #1;
    check(nm, exp);
  endtask

  task automatic add(input logic e, input logic ld, input logic [W-1:0] v,
                     input logic [4:0] exp);
    vec_t r;
    r.en = e; r.ld = ld; r.val = v; r.exp = exp;
    tbl.push_back(r);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;

    // Divide-by-4 from reset: tick every 4th edge, div_clk 2 high / 2 low.
    add(1,0,0,5'b00000); add(1,0,0,5'b10000); add(1,0,0,5'b10000); add(1,0,0,5'b01000);
    add(1,0,0,5'b00000); add(1,0,0,5'b10000); add(1,0,0,5'b10000); add(1,0,0,5'b01000);
    // Load 5: pending, applied at wrap with ack, then 3 high / 2 low.
    add(1,1,5,5'b00100); add(1,0,0,5'b10100); add(1,0,0,5'b10100); add(1,0,0,5'b01010);
    add(1,0,0,5'b00000); add(1,0,0,5'b10000); add(1,0,0,5'b10000); add(1,0,0,5'b10000);
    add(1,0,0,5'b01000); add(1,0,0,5'b00000); add(1,0,0,5'b10000); add(1,0,0,5'b10000);
    add(1,0,0,5'b10000); add(1,0,0,5'b01000);
    // Load 0 rejected: err pulse, no pend, period stays 5.
    add(1,1,0,5'b00001); add(1,0,0,5'b10000); add(1,0,0,5'b10000); add(1,0,0,5'b10000);
    add(1,0,0,5'b01000);
    // Switch to 8, then load 6 at cnt=2 and 3 at cnt=5; one ack, N becomes 3.
    add(1,1,8,5'b00100); add(1,0,0,5'b10100); add(1,0,0,5'b10100); add(1,0,0,5'b10100);
    add(1,0,0,5'b01010); add(1,0,0,5'b00000); add(1,0,0,5'b00000); add(1,1,6,5'b00100);
    add(1,0,0,5'b10100); add(1,0,0,5'b10100); add(1,1,3,5'b10100); add(1,0,0,5'b10100);
    add(1,0,0,5'b01010); add(1,0,0,5'b10000); add(1,0,0,5'b10000); add(1,0,0,5'b01000);
    add(1,0,0,5'b10000);

    // Reset state, including a load and enable presented while held in reset.
    #2;
    check("rst_init", 5'b00000);
    bus.en = 1'b1; bus.div_load = 1'b1; bus.div_val = 8'd5;
    @(posedge clk); #1;
    check("rst_hold", 5'b00000);
    @(posedge clk); #1;
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].val, tbl[i].exp, $sformatf("tbl%0d", i + 1));
    end

    // Fresh start at N=4 for the idle-apply case.
    bus.en = 1'b0;
    reset  = 1'b0;
    #1;
    check("rst_mid_tbl", 5'b00000);
    @(negedge clk);
    reset = 1'b1;

    // en dropped with a load pending: applied while idle, then 6-cycle period.
    step(1,1,6,5'b00100,"idle_ld");
    step(1,0,0,5'b10100,"idle_run");
    step(0,0,0,5'b00010,"idle_apply");
    step(0,0,0,5'b00000,"idle_hold");
    step(1,0,0,5'b00000,"n6_c1");
    step(1,0,0,5'b00000,"n6_c2");
    step(1,0,0,5'b10000,"n6_c3");
    step(1,0,0,5'b10000,"n6_c4");
    step(1,0,0,5'b10000,"n6_c5");
    step(1,0,0,5'b01000,"n6_tick");

    // Asynchronous reset mid-period with a divisor pending.
    step(1,1,3,5'b00100,"ar_ld");
    step(1,0,0,5'b00100,"ar_c2");
    step(1,0,0,5'b10100,"ar_c3");
    reset = 1'b0;
    #2;
    check("ar_immediate", 5'b00000);
    @(posedge clk); #1;
    check("ar_held", 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    step(1,0,0,5'b00000,"ar_n4_c1");
    step(1,0,0,5'b10000,"ar_n4_c2");
    step(1,0,0,5'b10000,"ar_n4_c3");
    step(1,0,0,5'b01000,"ar_n4_tick");

    // Load coinciding with the apply edge: old shadow (7) applied, 2 pending.
    step(1,1,7,5'b00100,"co_ld7");
    step(1,0,0,5'b10100,"co_c2");
    step(1,0,0,5'b10100,"co_c3");
    step(1,1,2,5'b01110,"co_apply7");
    step(1,0,0,5'b00100,"co_n7_c1");
    step(1,0,0,5'b00100,"co_n7_c2");
    step(1,0,0,5'b10100,"co_n7_c3");
    step(1,0,0,5'b10100,"co_n7_c4");
    step(1,0,0,5'b10100,"co_n7_c5");
    step(1,0,0,5'b10100,"co_n7_c6");
    step(1,0,0,5'b01010,"co_apply2");
    step(1,0,0,5'b10000,"co_n2_c1");
    step(1,0,0,5'b01000,"co_n2_tick");

    // Divide-by-1: tick and div_clk stay high continuously.
    step(1,1,1,5'b10100,"n1_ld");
    step(1,0,0,5'b11010,"n1_apply");
    step(1,0,0,5'b11000,"n1_c1");
    step(1,0,0,5'b11000,"n1_c2");
    step(1,0,0,5'b11000,"n1_c3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_prog_clk_divider
